// File: rtl/ysyx_24090018_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, FSM states, exception causes.
package ysyx_24090018_lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_LD_MIS = 2'b01;
  localparam logic [1:0] CAUSE_ST_MIS = 2'b10;
  localparam logic [1:0] CAUSE_ILL    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    RESP   = 2'b11
  } lsu_state_e;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == SB) || (f3 == SH) || (f3 == SW);
  endfunction

  // Halfwords need a[0]=0, words need a[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_24090018_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module ysyx_24090018_load_align
  import ysyx_24090018_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  assign lane = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      LB:      data_o = {{24{lane[7]}}, lane[7:0]};
      LH:      data_o = {{16{lane[15]}}, lane[15:0]};
      LBU:     data_o = {24'h0, lane[7:0]};
      LHU:     data_o = {16'h0, lane[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_24090018_lsu.sv
// EX-stage load/store unit: one op in flight, req/ready/rvalid memory port, valid/ready write-back.
module ysyx_24090018_lsu
  import ysyx_24090018_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_alu_i,
  input  logic [31:0]       in_wdata_i,
  input  logic              in_is_load_i,
  input  logic              in_is_store_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [4:0]        in_rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [31:0]       wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_we_o,
  output logic              wb_exc_o,
  output logic [1:0]        wb_cause_o
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              mem_we_q, mem_we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              wb_we_q, wb_we_d;
  logic              wb_exc_q, wb_exc_d;
  logic [1:0]        cause_q, cause_d;

  logic [ADDR_W-1:0] a_eff;
  logic              f3_legal;
  logic              mis;
  logic [31:0]       ld_data;

  // Without alignment checking the address is snapped to the access size instead.
  always_comb begin
    a_eff = in_alu_i;
    if (ALIGN_CHECK == 0) begin
      if (in_funct3_i[1:0] == 2'b01) a_eff[0] = 1'b0;
      else if (in_funct3_i[1:0] == 2'b10) a_eff[1:0] = 2'b00;
    end
  end

  assign f3_legal = in_is_load_i ? load_f3_legal(in_funct3_i) : store_f3_legal(in_funct3_i);
  assign mis      = (ALIGN_CHECK != 0) && is_misaligned(in_funct3_i, in_alu_i[1:0]);

  ysyx_24090018_load_align u_load_align (
    .rdata_i   (mem_rdata_i),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .data_o    (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    mem_we_d  = mem_we_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wb_we_d   = wb_we_q;
    wb_exc_d  = wb_exc_q;
    cause_d   = cause_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          funct3_d = in_funct3_i;
          rd_d     = in_rd_i;
          wb_exc_d = 1'b0;
          cause_d  = CAUSE_NONE;
          if (!in_is_load_i && !in_is_store_i) begin
            wb_data_d = 32'(in_alu_i);
            wb_we_d   = (in_rd_i != 5'd0);
            state_d   = RESP;
          end else if (!f3_legal || mis) begin
            // Faults report the address exactly as the ALU produced it.
            wb_data_d = 32'(in_alu_i);
            wb_we_d   = 1'b0;
            wb_exc_d  = 1'b1;
            cause_d   = !f3_legal ? CAUSE_ILL : (in_is_load_i ? CAUSE_LD_MIS : CAUSE_ST_MIS);
            state_d   = RESP;
          end else begin
            addr_d   = a_eff;
            mem_we_d = !in_is_load_i;
            wdata_d  = in_wdata_i;
            wstrb_d  = 4'b0000;
            if (!in_is_load_i) begin
              case (in_funct3_i)
                SB: begin
                  wdata_d = {4{in_wdata_i[7:0]}};
                  wstrb_d = 4'b0001 << a_eff[1:0];
                end
                SH: begin
                  wdata_d = {2{in_wdata_i[15:0]}};
                  wstrb_d = 4'b0011 << a_eff[1:0];
                end
                default: wstrb_d = 4'b1111;
              endcase
            end
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          if (mem_we_q) begin
            wb_data_d = 32'h0;
            wb_we_d   = 1'b0;
            state_d   = RESP;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (mem_rvalid_i) begin
          wb_data_d = ld_data;
          wb_we_d   = (rd_q != 5'd0);
          state_d   = RESP;
        end
      end
      RESP: begin
        if (wb_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_we_q  <= 1'b0;
      funct3_q  <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
      wb_exc_q  <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      mem_we_q  <= mem_we_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
      wb_exc_q  <= wb_exc_d;
      cause_q   <= cause_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = (state_q == REQ) && mem_we_q;
  assign mem_wstrb_o = (state_q == REQ) ? wstrb_q : 4'b0000;
  assign mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata_o = wdata_q;
  assign wb_valid_o  = (state_q == RESP);
  assign wb_data_o   = wb_data_q;
  assign wb_rd_o     = rd_q;
  assign wb_we_o     = (state_q == RESP) && wb_we_q;
  assign wb_exc_o    = (state_q == RESP) && wb_exc_q;
  assign wb_cause_o  = cause_q;

endmodule

// File: tb/tb_ysyx_24090018_lsu.sv
// Directed scoreboard bench for the load/store unit.
module tb_ysyx_24090018_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i, in_ready_o;
  logic [31:0] in_alu_i, in_wdata_i;
  logic        in_is_load_i, in_is_store_i;
  logic [2:0]  in_funct3_i;
  logic [4:0]  in_rd_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o, wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o, wb_exc_o;
  logic [1:0]  wb_cause_o;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ysyx_24090018_lsu #(.ADDR_W(32), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_alu_i(in_alu_i),
    .in_wdata_i(in_wdata_i), .in_is_load_i(in_is_load_i), .in_is_store_i(in_is_store_i),
    .in_funct3_i(in_funct3_i), .in_rd_i(in_rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_exc_o(wb_exc_o), .wb_cause_o(wb_cause_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] alu, input logic [31:0] wd, input logic ld,
                      input logic st, input logic [2:0] f3, input logic [4:0] rd);
    chk("in_ready_before_send", in_ready_o, 1);
    in_valid_i = 1; in_alu_i = alu; in_wdata_i = wd;
    in_is_load_i = ld; in_is_store_i = st; in_funct3_i = f3; in_rd_i = rd;
    step();
    in_valid_i = 0; in_alu_i = 0; in_wdata_i = 0;
    in_is_load_i = 0; in_is_store_i = 0; in_funct3_i = 0; in_rd_i = 0;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic we,
                      input logic exc, input logic [1:0] cause);
    exp_t e;
    e.data = d; e.rd = rd; e.we = we; e.exc = exc; e.cause = cause;
    sb_q.push_back(e);
  endtask

  task automatic wait_wb(input int budget, input int hold);
    exp_t e;
    int n = 0;
    while (!wb_valid_o && n < budget) begin
      step();
      n++;
    end
    chk("wb_valid_within_budget", wb_valid_o, 1);
    chk("scoreboard_has_entry", sb_q.size() != 0, 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk("wb_data", wb_data_o, e.data);
    chk("wb_rd", wb_rd_o, e.rd);
    chk("wb_we", wb_we_o, e.we);
    chk("wb_exc", wb_exc_o, e.exc);
    if (e.exc) chk("wb_cause", wb_cause_o, e.cause);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_wb_valid", wb_valid_o, 1);
      chk("hold_wb_data", wb_data_o, e.data);
      chk("hold_wb_we", wb_we_o, e.we);
      chk("hold_in_ready", in_ready_o, 0);
    end
    wb_ready_i = 1;
    step();
    wb_ready_i = 0;
    chk("wb_valid_after_hs", wb_valid_o, 0);
    chk("in_ready_after_hs", in_ready_o, 1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [31:0] exp, input int rv_delay);
    push(exp, rd, rd != 0, 0, 0);
    send(a, 32'h0, 1, 0, f3, rd);
    chk("ld_mem_req", mem_req_o, 1);
    chk("ld_mem_we", mem_we_o, 0);
    chk("ld_mem_wstrb", mem_wstrb_o, 0);
    chk("ld_mem_addr", mem_addr_o, {a[31:2], 2'b00});
    mem_ready_i = 1;
    step();
    mem_ready_i = 0;
    chk("ld_req_dropped", mem_req_o, 0);
    for (int i = 0; i < rv_delay; i++) begin
      step();
      chk("ld_wait_no_wb", wb_valid_o, 0);
    end
    mem_rvalid_i = 1; mem_rdata_i = rdata;
    step();
    mem_rvalid_i = 0; mem_rdata_i = 32'h0;
    chk("ld_wb_valid_3_edges", wb_valid_o, 1);
    wait_wb(2, 0);
  endtask

  task automatic do_exc(input logic [31:0] a, input logic ld, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [1:0] cause);
    push(a, rd, 0, 1, cause);
    send(a, 32'h12345678, ld, !ld, f3, rd);
    chk("exc_no_mem_req", mem_req_o, 0);
    wait_wb(1, 0);
  endtask

  initial begin
    rst_n = 0; in_valid_i = 0; in_alu_i = 0; in_wdata_i = 0;
    in_is_load_i = 0; in_is_store_i = 0; in_funct3_i = 0; in_rd_i = 0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; wb_ready_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_mem_wstrb", mem_wstrb_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_wb_we", wb_we_o, 0);
    chk("rst_wb_exc", wb_exc_o, 0);
    chk("rst_wb_cause", wb_cause_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    rst_n = 1;
    step();

    // Pass-through ops
    push(32'h0000_1234, 5'd5, 1, 0, 0);
    send(32'h0000_1234, 32'h0, 0, 0, 3'b000, 5'd5);
    chk("alu_latency_1", wb_valid_o, 1);
    wait_wb(1, 0);
    push(32'h0000_1234, 5'd0, 0, 0, 0);
    send(32'h0000_1234, 32'h0, 0, 0, 3'b000, 5'd0);
    wait_wb(1, 0);

    // sb with a stalled memory port
    push(32'h0, 5'd7, 0, 0, 0);
    send(32'h8000_0003, 32'hAABB_CCDD, 0, 1, 3'b000, 5'd7);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("sb_mem_req", mem_req_o, 1);
      chk("sb_mem_we", mem_we_o, 1);
      chk("sb_mem_addr", mem_addr_o, 32'h8000_0000);
      chk("sb_mem_wstrb", mem_wstrb_o, 4'b1000);
      chk("sb_mem_wdata", mem_wdata_o, 32'hDDDD_DDDD);
      chk("sb_in_ready", in_ready_o, 0);
    end
    mem_ready_i = 1;
    step();
    mem_ready_i = 0;
    chk("sb_req_dropped", mem_req_o, 0);
    wait_wb(1, 0);

    // sh upper half and sw
    push(32'h0, 5'd1, 0, 0, 0);
    send(32'h8000_0102, 32'h1111_BEEF, 0, 1, 3'b001, 5'd1);
    chk("sh_mem_wstrb", mem_wstrb_o, 4'b1100);
    chk("sh_mem_wdata", mem_wdata_o, 32'hBEEF_BEEF);
    chk("sh_mem_addr", mem_addr_o, 32'h8000_0100);
    mem_ready_i = 1; step(); mem_ready_i = 0;
    wait_wb(1, 0);
    push(32'h0, 5'd2, 0, 0, 0);
    send(32'h8000_0208, 32'hCAFE_F00D, 0, 1, 3'b010, 5'd2);
    chk("sw_mem_wstrb", mem_wstrb_o, 4'b1111);
    chk("sw_mem_wdata", mem_wdata_o, 32'hCAFE_F00D);
    mem_ready_i = 1; step(); mem_ready_i = 0;
    wait_wb(1, 0);

    // Loads
    do_load(32'h8000_0002, 3'b000, 5'd3, 32'h1180_2233, 32'hFFFF_FF80, 0);
    do_load(32'h8000_0002, 3'b100, 5'd3, 32'h1180_2233, 32'h0000_0080, 0);
    do_load(32'h8000_0002, 3'b101, 5'd4, 32'h1180_2233, 32'h0000_1180, 2);
    do_load(32'h8000_0000, 3'b001, 5'd6, 32'h0000_8001, 32'hFFFF_8001, 0);
    do_load(32'h8000_0003, 3'b000, 5'd8, 32'h7F00_0000, 32'h0000_007F, 1);
    do_load(32'h8000_0004, 3'b010, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);

    // Exceptions
    do_exc(32'h8000_0006, 1, 3'b010, 5'd9, 2'b01);
    do_exc(32'h8000_0001, 1, 3'b101, 5'd9, 2'b01);
    do_exc(32'h8000_0001, 0, 3'b001, 5'd9, 2'b10);
    do_exc(32'h8000_0000, 1, 3'b011, 5'd9, 2'b11);
    do_exc(32'h8000_0000, 0, 3'b100, 5'd9, 2'b11);

    // Write-back back-pressure
    push(32'h0000_BEEF, 5'd10, 1, 0, 0);
    send(32'h0000_BEEF, 32'h0, 0, 0, 3'b000, 5'd10);
    wait_wb(1, 4);
    push(32'h0000_0042, 5'd11, 1, 0, 0);
    send(32'h0000_0042, 32'h0, 0, 0, 3'b000, 5'd11);
    wait_wb(1, 0);

    // Reset while waiting for read data
    send(32'h8000_0010, 32'h0, 1, 0, 3'b010, 5'd12);
    mem_ready_i = 1; step(); mem_ready_i = 0;
    rst_n = 0;
    #1;
    chk("rst_wait_mem_req", mem_req_o, 0);
    chk("rst_wait_wb_valid", wb_valid_o, 0);
    step();
    rst_n = 1;
    mem_rvalid_i = 1; mem_rdata_i = 32'h5555_5555;
    step();
    mem_rvalid_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_rvalid_no_wb", wb_valid_o, 0);
      step();
    end

    // Reset while a request is outstanding
    send(32'h8000_0020, 32'h0, 0, 1, 3'b010, 5'd13);
    chk("req_before_rst", mem_req_o, 1);
    rst_n = 0;
    #1;
    chk("rst_req_mem_req", mem_req_o, 0);
    chk("rst_req_mem_we", mem_we_o, 0);
    chk("rst_req_mem_addr", mem_addr_o, 0);
    step();
    rst_n = 1;
    step();

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24090018_lsu.md
Name: ysyx_24090018_lsu

Overview:
Load/store unit that sits directly downstream of the 32-bit ALU in the EX stage.
- Takes the ALU result as the effective address, or as pass-through data for non-memory ops.
- Performs byte/half/word loads and stores over a req/ready/rvalid memory port.
- Hands the result to write-back through a valid/ready handshake.
- One operation in flight at a time; multi-cycle memory stalls upstream through in_ready_o.

Parameters:
ADDR_W, 32, address width, also the ALU result width.
ALIGN_CHECK, 1, 1 = detect misalignment and raise an exception; 0 = force address low bits to the natural alignment.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid_i  input  1  EX has an op.
in_ready_o  output  1  LSU accepts an op.
in_alu_i  input  ADDR_W  ALU result: address or pass-through value.
in_wdata_i  input  32  store data (rs2).
in_is_load_i  input  1  op is a load.
in_is_store_i  input  1  op is a store.
in_funct3_i  input  3  width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
in_rd_i  input  5  destination register.
mem_req_o  output  1  memory request.
mem_we_o  output  1  1 = write.
mem_addr_o  output  ADDR_W  word-aligned address.
mem_wdata_o  output  32  write data, lane-replicated.
mem_wstrb_o  output  4  byte enables.
mem_ready_i  input  1  request accepted this cycle.
mem_rvalid_i  input  1  read data valid.
mem_rdata_i  input  32  read word.
wb_valid_o  output  1  result valid.
wb_ready_i  input  1  WB accepts.
wb_data_o  output  32  result.
wb_rd_o  output  5  destination register.
wb_we_o  output  1  register-file write enable.
wb_exc_o  output  1  exception.
wb_cause_o  output  2  01 load misaligned, 10 store misaligned, 11 illegal funct3.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset:
  - FSM goes to IDLE.
  - mem_req_o, mem_we_o, wb_valid_o, wb_we_o, wb_exc_o are 0.
  - All data, address, strobe and cause outputs are 0.
  - Reset mid-operation abandons the op; mem_req_o drops immediately.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- in_ready_o = (state == IDLE). An op is accepted when in_valid_i & in_ready_o; all inputs are latched at that edge.
- Op with neither load nor store: go to RESP. wb_data_o = in_alu_i, wb_we_o = (rd != 0). Latency 1 cycle.
- Memory op with illegal funct3 (load 011/110/111; store other than 000/001/010), or misaligned address with ALIGN_CHECK = 1:
  - Misaligned means h/hu with a[0] = 1, or w with a[1:0] != 0.
  - No memory request is issued; go to RESP with wb_exc_o = 1, wb_we_o = 0, wb_data_o = faulting address, wb_cause_o set.
- REQ state:
  - mem_req_o = 1 and mem_addr_o = {a[ADDR_W-1:2], 2'b00}.
  - All mem_* outputs are held stable until mem_ready_i.
  - Store: mem_we_o = 1.
    - sb: wstrb = 0001 << a[1:0], wdata = {4{wdata[7:0]}}.
    - sh: wstrb = 0011 << a[1:0], wdata = {2{wdata[15:0]}}.
    - sw: wstrb = 1111.
    - On mem_ready_i go to RESP with wb_we_o = 0 and wb_data_o = 0.
  - Load: mem_we_o = 0, wstrb = 0. On mem_ready_i go to WAIT_R.
- WAIT_R state:
  - Wait for mem_rvalid_i, which arrives no earlier than the cycle after acceptance.
  - Extract the lane selected by a[1:0]; sign-extend for b/h, zero-extend for bu/hu.
  - Register the result, wb_we_o = (rd != 0), go to RESP.
  - Minimum load latency: accept→RESP is 3 edges.
- RESP state: wb_valid_o = 1, with all wb_* held until wb_ready_i; then go to IDLE.
- mem_rvalid_i outside WAIT_R is ignored.
- No back-to-back overlap: the next op is accepted at the earliest one cycle after the RESP handshake.

Decomposition:
- Package ysyx_24090018_lsu_pkg holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the FSM state enum;
  - cause codes (CAUSE_LD_MIS, CAUSE_ST_MIS, CAUSE_ILL).
- One combinational sub-module, ysyx_24090018_load_align: inputs rdata, a[1:0], funct3; output is the extended 32-bit result.

Test Plan:
- Non-memory op, alu = 0x0000_1234, rd = 5 → wb_valid after 1 edge, wb_data = 0x1234, wb_we = 1; rd = 0 → wb_we = 0.
- sb, addr = 0x8000_0003, wdata = 0xAABBCCDD → mem_addr = 0x8000_0000, wstrb = 1000, wdata = 0xDDDDDDDD; mem_ready stalled for 3 cycles → outputs held stable, in_ready = 0.
- lb, addr = 0x8000_0002, rdata = 0x1180_2233 → wb_data = 0xFFFF_FF80; lbu → 0x0000_0080; lhu at 0x...2 → 0x0000_1180.
- lw, addr = 0x8000_0006 → no mem_req, wb_exc = 1, cause = 01, wb_data = 0x8000_0006; sh at 0x...1 → cause = 10; load funct3 = 011 → cause = 11.
- wb_ready held low for 4 cycles in RESP → wb_* stable, in_ready = 0; the op is accepted the cycle after the handshake.
- rst_n asserted while in WAIT_R → mem_req and wb_valid are 0 immediately; a stray later mem_rvalid produces no wb_valid.
